// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and constants for the unified-memory port arbiter.
//   - arb_state_e : arbiter FSM state encoding (idle / fetch owner / data owner)
//   - FUNCT3_WORD : access size driven to the memory for instruction fetches
//   - STREAK_W / TMO_W : widths of the anti-starvation and timeout counters
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_e;

  // Fetches are always full 32-bit words.
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  localparam int STREAK_W = 4;
  localparam int TMO_W    = 8;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-ported unified instruction/data memory between the IF
//   stage (fetch) and the MEM stage (load/store). Data accesses win by
//   default; a streak counter hands the port to a waiting fetch after
//   DATA_STREAK_MAX back-to-back data grants. A timeout counter aborts an
//   access the memory never acknowledges and flags it on arb_err.
//
// Parameters
//   DATA_STREAK_MAX  max consecutive data grants while if_req waits (1..15)
//   TIMEOUT          busy cycles without mem_ack before abort (0 = off, <=255)
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   if_req/if_addr           fetch request (held until if_ready) and address
//   if_rdata/if_ready        fetch data and 1-cycle completion pulse
//   dm_read/dm_write         load / store request (held until dm_ready)
//   dm_addr/dm_wdata/dm_funct3  data address, store data, access size/sign
//   dm_rdata/dm_ready        load data and 1-cycle completion pulse
//   mem_en/mem_we            memory strobe (held until mem_ack), write enable
//   mem_addr/mem_wdata/mem_funct3  latched access attributes
//   mem_rdata/mem_ack        memory read data and completion
//   stall_if/stall_mem       stall levels for the hazard unit
//   arb_err                  1-cycle pulse after a timeout abort
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_STREAK_MAX = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,

  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_funct3,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,

  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,

  output logic        stall_if,
  output logic        stall_mem,
  output logic        arb_err
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(DATA_STREAK_MAX);
  localparam logic [TMO_W-1:0]    TMO_LAST     = TMO_W'(TIMEOUT - 1);
  localparam bit                  TMO_ON       = (TIMEOUT != 0);

  arb_state_e          state;
  logic [STREAK_W-1:0] streak;
  logic [TMO_W-1:0]    tmo_cnt;

  logic dm_req;
  logic grant_data;
  logic tmo_hit;

  assign dm_req = dm_read | dm_write;

  // A waiting fetch only blocks data once the streak limit is reached.
  assign grant_data = dm_req && ((streak < STREAK_LIMIT) || !if_req);

  // An ack in the same cycle takes priority over the abort.
  assign tmo_hit = TMO_ON && (tmo_cnt == TMO_LAST) && !mem_ack;

  // mem_en is a pure decode of the state flop, so an async reset drops it
  // immediately without waiting for a clock edge.
  assign mem_en = (state != ARB_IDLE);

  // Completion is combinational with mem_ack so a first-cycle ack finishes
  // the access without an extra bubble.
  assign if_ready = (state == ARB_FETCH) && mem_ack;
  assign dm_ready = (state == ARB_DATA)  && mem_ack;
  assign if_rdata = if_ready ? mem_rdata : '0;
  assign dm_rdata = dm_ready ? mem_rdata : '0;

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dm_req & ~dm_ready;

  // NOTE: every register here is updated with non-blocking assignments so all
  // flops sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      streak     <= '0;
      tmo_cnt    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_funct3 <= '0;
      arb_err    <= 1'b0;
    end else begin
      arb_err <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_data) begin
            state      <= ARB_DATA;
            mem_we     <= dm_write;  // write wins if both are raised
            mem_addr   <= dm_addr;
            mem_wdata  <= dm_wdata;
            mem_funct3 <= dm_funct3;
            tmo_cnt    <= '0;
            streak     <= if_req ? streak + STREAK_W'(1) : '0;
          end else if (if_req) begin
            state      <= ARB_FETCH;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_funct3 <= FUNCT3_WORD;
            tmo_cnt    <= '0;
            streak     <= '0;
          end
        end

        ARB_FETCH, ARB_DATA: begin
          if (mem_ack) begin
            state <= ARB_IDLE;
          end else if (tmo_hit) begin
            // Abort: the still-held request is re-arbitrated from IDLE.
            state   <= ARB_IDLE;
            arb_err <= 1'b1;
          end else if (TMO_ON) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_funct3;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        arb_err;

  mem_port_arbiter #(.DATA_STREAK_MAX(4), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ready   (if_ready),
    .dm_read    (dm_read),
    .dm_write   (dm_write),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_funct3  (dm_funct3),
    .dm_rdata   (dm_rdata),
    .dm_ready   (dm_ready),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_funct3 (mem_funct3),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .stall_if   (stall_if),
    .stall_mem  (stall_mem),
    .arb_err    (arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  int lat       = 0;
  bit ack_en    = 1'b1;
  bit ack_force = 1'b0;
  int wait_cnt  = 0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0000_0093;
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) begin
    if (!mem_en || mem_ack) wait_cnt <= 0;
    else                    wait_cnt <= wait_cnt + 1;
  end

  assign mem_ack   = ack_force || (ack_en && mem_en && (wait_cnt == lat));
  assign mem_rdata = mem_en ? mem_model(mem_addr) : 32'h0;

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  localparam logic [2:0] K_FETCH = 3'b001;
  localparam logic [2:0] K_DATA  = 3'b010;
  localparam logic [2:0] K_ERR   = 3'b100;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] addr;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic push_fetch(input logic [31:0] a, input logic [31:0] rd);
    sb.push_back('{K_FETCH, a, 1'b0, 3'b010, 32'h0, rd});
  endtask
  task automatic push_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] rd);
    sb.push_back('{K_DATA, a, 1'b0, f3, 32'h0, rd});
  endtask
  task automatic push_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    sb.push_back('{K_DATA, a, 1'b1, f3, wd, 32'h0});
  endtask
  task automatic push_err();
    sb.push_back('{K_ERR, 32'h0, 1'b0, 3'b000, 32'h0, 32'h0});
  endtask

  // Scoreboard monitor: pops one expectation per completion / abort event.
  always @(negedge clk) begin
    if (rst && (if_ready || dm_ready || arb_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {29'b0, arb_err, dm_ready, if_ready}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("event_kind", {29'b0, arb_err, dm_ready, if_ready}, {29'b0, mon_e.kind});
        if (mon_e.kind != K_ERR) begin
          check("mem_addr", mem_addr, mon_e.addr);
          check("mem_we", {31'b0, mem_we}, {31'b0, mon_e.we});
          check("mem_funct3", {29'b0, mem_funct3}, {29'b0, mon_e.f3});
          if (mon_e.kind == K_FETCH)  check("if_rdata", if_rdata, mon_e.rdata);
          else if (mon_e.we)          check("mem_wdata", mem_wdata, mon_e.wdata);
          else                        check("dm_rdata", dm_rdata, mon_e.rdata);
        end
      end
    end
  end

  // Stability / pulse-width monitor, enabled for the slow-memory phase.
  bit          stab_on = 1'b0;
  logic        prev_en = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [2:0]  prev_f3;

  always @(negedge clk) begin
    if (stab_on) begin
      if (mem_en && prev_en) begin
        check("hold_addr", mem_addr, prev_addr);
        check("hold_wdata", mem_wdata, prev_wdata);
        check("hold_funct3", {29'b0, mem_funct3}, {29'b0, prev_f3});
      end
      if (prev_rdy) check("ready_width", {30'b0, if_ready, dm_ready}, 32'h0);
    end
    prev_en    = mem_en;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
    prev_f3    = mem_funct3;
    prev_rdy   = if_ready | dm_ready;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input string name, input bit data_side, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      cycles++;
      seen = data_side ? dm_ready : if_ready;
    end
    check({name, "_seen"}, {31'b0, seen}, 32'h1);
    step();
  endtask

  // Both requesters keep their request high and move to the next address
  // after each completion, like a pipeline that always has work queued.
  task automatic run_grants(input int want, output int got);
    logic rd, ri;
    got = 0;
    for (int i = 0; i < 200 && got < want; i++) begin
      @(negedge clk);
      rd = dm_ready;
      ri = if_ready;
      step();
      if (rd) dm_addr = dm_addr + 32'd4;
      if (ri) if_addr = if_addr + 32'd4;
      got = got + int'(rd) + int'(ri);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ctl"}, {25'b0, mem_en, mem_we, if_ready, dm_ready, arb_err, 2'b0}, 32'h0);
    check({name, "_addr"}, mem_addr, 32'h0);
    check({name, "_wdata"}, mem_wdata, 32'h0);
    check({name, "_funct3"}, {29'b0, mem_funct3}, 32'h0);
    check({name, "_rdata"}, if_rdata | dm_rdata, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  int got, cyc, t0, te;

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_read = 1'b0; dm_write = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_funct3 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_stall", {30'b0, stall_if, stall_mem}, 32'h0);
    step();
    rst = 1'b1;

    // Fetch only: ready in the second cycle of the request
    if_req = 1'b1; if_addr = 32'h100;
    push_fetch(32'h100, 32'h0000_0093);
    @(negedge clk);
    check("t1_cycle1", {29'b0, mem_en, if_ready, stall_if}, 32'b001);
    @(negedge clk);
    check("t1_cycle2", {29'b0, mem_en, if_ready, stall_if}, 32'b110);
    check("t1_rdata", if_rdata, 32'h0000_0093);
    step();
    if_req = 1'b0;

    // Simultaneous fetch and store (read also raised: write must win)
    if_req = 1'b1; if_addr = 32'h200;
    dm_write = 1'b1; dm_read = 1'b1; dm_addr = 32'h2000;
    dm_wdata = 32'hDEAD_BEEF; dm_funct3 = 3'b000;
    push_store(32'h2000, 32'hDEAD_BEEF, 3'b000);
    push_fetch(32'h200, mem_model(32'h200));
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      check("t2_stall_if", {31'b0, stall_if}, 32'h1);
      check("t2_stall_mem", {31'b0, stall_mem}, {31'b0, ~dm_ready});
      got = int'(dm_ready);
    end
    check("t2_store_done", got, 1);
    step();
    dm_write = 1'b0; dm_read = 1'b0;
    wait_rdy("t2_fetch", 1'b0, cyc);
    if_req = 1'b0;

    // Streak: 4 data grants, 1 fetch, repeated
    dm_read = 1'b1; dm_funct3 = 3'b010; dm_addr = 32'h3000;
    if_req = 1'b1; if_addr = 32'h400;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) push_fetch(32'h400 + 32'd4 * ((k == 4) ? 32'd0 : 32'd1),
                                       mem_model(32'h400 + 32'd4 * ((k == 4) ? 32'd0 : 32'd1)));
      else push_load(32'h3000 + 32'd4 * 32'(k - ((k > 4) ? 1 : 0)), 3'b010,
                     mem_model(32'h3000 + 32'd4 * 32'(k - ((k > 4) ? 1 : 0))));
    end
    run_grants(10, got);
    check("t3_grants", got, 10);
    dm_read = 1'b0; if_req = 1'b0;

    // Timeout: no ack -> arb_err 8 cycles after mem_en rose, then re-grant
    ack_en = 1'b0;
    dm_read = 1'b1; dm_addr = 32'h5000; dm_funct3 = 3'b010;
    push_err();
    push_load(32'h5000, 3'b010, mem_model(32'h5000));
    t0 = -1; te = -1;
    for (int i = 0; i < 40 && te < 0; i++) begin
      @(negedge clk);
      if (mem_en && t0 < 0) t0 = i;
      if (arb_err) begin
        te = i;
        check("t4_err_idle", {31'b0, mem_en}, 32'h0);
      end
    end
    check("t4_err_delay", te - t0, 8);
    ack_en = 1'b1;
    @(negedge clk);
    check("t4_regrant", {30'b0, dm_ready, arb_err}, 32'b10);
    step();
    dm_read = 1'b0;

    // Reset mid-access: streak must restart from zero afterwards
    if_req = 1'b1; if_addr = 32'h900;
    dm_read = 1'b1; dm_addr = 32'h6000; dm_funct3 = 3'b010;
    push_load(32'h6000, 3'b010, mem_model(32'h6000));
    push_load(32'h6004, 3'b010, mem_model(32'h6004));
    run_grants(2, got);
    check("t5_pre_grants", got, 2);
    ack_en = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      got = int'(mem_en);
    end
    check("t5_busy", got, 1);
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("t5_reset");
    check("t5_stall", {30'b0, stall_if, stall_mem}, 32'b11);
    repeat (2) @(posedge clk);
    ack_en = 1'b1;
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++)
      push_load(32'h6008 + 32'd4 * 32'(k), 3'b010, mem_model(32'h6008 + 32'd4 * 32'(k)));
    push_fetch(32'h900, mem_model(32'h900));
    run_grants(5, got);
    check("t5_post_grants", got, 5);
    dm_read = 1'b0; if_req = 1'b0;

    // Latency 3, alternating load / fetch
    lat = 3;
    stab_on = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        dm_read = 1'b1; dm_addr = 32'h7000 + 32'd4 * 32'(k);
        dm_wdata = 32'h1234_0000 + 32'(k); dm_funct3 = (k == 0) ? 3'b100 : 3'b001;
        push_load(dm_addr, dm_funct3, mem_model(dm_addr));
        wait_rdy("t6_load", 1'b1, cyc);
        dm_read = 1'b0;
      end else begin
        if_req = 1'b1; if_addr = 32'h800 + 32'd4 * 32'(k);
        push_fetch(if_addr, mem_model(if_addr));
        wait_rdy("t6_fetch", 1'b0, cyc);
        if_req = 1'b0;
      end
      check("t6_latency", cyc, 5);
    end
    stab_on = 1'b0;
    lat = 0;

    // mem_ack while idle is ignored
    ack_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t7_idle_ack", {29'b0, mem_en, if_ready, dm_ready}, 32'h0);
    end
    ack_force = 1'b0;

    repeat (3) step();
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_port_arbiter
